// File: rtl/debounce_filter_pkg.sv
// Shared definitions for the debounce filter family.
//  - edge_e   : per-channel edge event held in the pulse register
//  - clog2    : ceiling log2 usable in constant expressions
//  - cnt_width: stability counter width for a given STABLE_CYCLES (min 1)
package debounce_filter_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) w = i + 1;
    end
    return w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned stable);
    int unsigned w;
    w = clog2(stable);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_filter_if.sv
// Bundle of the per-channel debounce signals.
//  tick_en : sample qualifier shared by all channels
//  din     : raw asynchronous inputs
//  db_out  : debounced levels
//  rise_p  : one-cycle pulse when db_out[i] goes 0->1
//  fall_p  : one-cycle pulse when db_out[i] goes 1->0
// master drives tick_en/din; slave (the filter) drives the outputs.
interface debounce_filter_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                tick_en;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] db_out;
  logic [CHANNELS-1:0] rise_p;
  logic [CHANNELS-1:0] fall_p;

  modport master (output tick_en, din, input db_out, rise_p, fall_p);
  modport slave  (input tick_en, din, output db_out, rise_p, fall_p);
endinterface

// File: rtl/debounce_filter_channel.sv
// One debounce channel: 2-FF synchroniser, saturating stability counter
// and registered rise/fall pulse pair.
//  clk, rst : clock and synchronous active-high reset
//  tick_en  : sample qualifier
//  din      : raw asynchronous input
//  db_out   : debounced level
//  rise_p   : high for the one cycle db_out first reads 1
//  fall_p   : high for the one cycle db_out first reads 0
module debounce_channel
  import debounce_filter_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic din,
  output logic db_out,
  output logic rise_p,
  output logic fall_p
);

  localparam int unsigned      CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  edge_e            edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= RESET_LEVEL;
      s2     <= RESET_LEVEL;
      cnt    <= '0;
      db_out <= RESET_LEVEL;
      edge_q <= EDGE_NONE;
    end else begin
      s1     <= din;
      s2     <= s1;
      edge_q <= EDGE_NONE;
      if (s2 == db_out) begin
        // Any return to the accepted level restarts the count.
        cnt <= '0;
      end else if (tick_en) begin
        if (cnt == LAST) begin
          db_out <= s2;
          cnt    <= '0;
          edge_q <= s2 ? EDGE_RISE : EDGE_FALL;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Pulses decode a single enum register, so rise and fall are mutually exclusive.
  assign rise_p = (edge_q == EDGE_RISE);
  assign fall_p = (edge_q == EDGE_FALL);

endmodule

// File: rtl/debounce_filter.sv
// Multi-channel debouncer / glitch filter for buttons and switches.
//  clk, rst : clock and synchronous active-high reset
//  bus      : debounce_filter_if slave (tick_en, din in; db_out, rise_p, fall_p out)
// Each channel is an independent debounce_channel; tick_en is shared.
module debounce_filter #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  debounce_filter_if.slave        bus
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick_en (bus.tick_en),
      .din     (bus.din[i]),
      .db_out  (bus.db_out[i]),
      .rise_p  (bus.rise_p[i]),
      .fall_p  (bus.fall_p[i])
    );
  end

endmodule

// File: tb/tb_debounce_filter.sv
module tb_debounce_filter;

  localparam int unsigned CH     = 4;
  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debounce_filter_if #(.CHANNELS(CH)) bus ();

  debounce_filter #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (STABLE),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [CH-1:0] db;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   asserts  = 0;
  int   failures = 0;

  // Reference model state: synchroniser image, accepted level and run length
  // of consecutive qualified samples at the new level.
  logic [CH-1:0] m_s1, m_s2, m_db;
  int unsigned   m_run[CH];

  // Drive one cycle of stimulus, push the predicted post-edge outputs,
  // then advance to just after the edge.
  task automatic step(input logic [CH-1:0] d, input logic t, input logic r);
    exp_t          e;
    logic [CH-1:0] nd;
    bus.din     = d;
    bus.tick_en = t;
    rst         = r;
    e.rise = '0;
    e.fall = '0;
    if (r) begin
      m_s1 = '0;
      m_s2 = '0;
      m_db = '0;
      for (int c = 0; c < CH; c++) m_run[c] = 0;
    end else begin
      nd = m_db;
      for (int c = 0; c < CH; c++) begin
        if (m_s2[c] == m_db[c]) begin
          m_run[c] = 0;
        end else if (t) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == STABLE) begin
            nd[c]     = m_s2[c];
            e.rise[c] = m_s2[c];
            e.fall[c] = ~m_s2[c];
            m_run[c]  = 0;
          end
        end
      end
      m_db = nd;
      m_s2 = m_s1;
      m_s1 = d;
    end
    e.db = m_db;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every cycle that has a prediction queued.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        asserts++;
        if (bus.db_out !== e.db) begin
          failures++;
          $display("FAIL sb_db_out t=%0t got=%b exp=%b", $time, bus.db_out, e.db);
        end
        asserts++;
        if (bus.rise_p !== e.rise) begin
          failures++;
          $display("FAIL sb_rise_p t=%0t got=%b exp=%b", $time, bus.rise_p, e.rise);
        end
        asserts++;
        if (bus.fall_p !== e.fall) begin
          failures++;
          $display("FAIL sb_fall_p t=%0t got=%b exp=%b", $time, bus.fall_p, e.fall);
        end
        asserts++;
        if ((bus.rise_p & bus.fall_p) !== '0) begin
          failures++;
          $display("FAIL sb_exclusive t=%0t rise=%b fall=%b exp=0000", $time, bus.rise_p, bus.fall_p);
        end
      end
    end
  end

  task automatic test_reset();
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    asserts++;
    if (bus.db_out !== 4'b0000 || bus.rise_p !== 4'b0000 || bus.fall_p !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state got db=%b rise=%b fall=%b exp all 0000", bus.db_out, bus.rise_p, bus.fall_p);
    end
  endtask

  task automatic test_clean_press();
    for (int k = 1; k <= 7; k++) begin
      step(4'b0001, 1'b1, 1'b0);
      if (k == 5) begin
        asserts++;
        if (bus.db_out[0] !== 1'b0) begin
          failures++;
          $display("FAIL press_early got=%b exp=0", bus.db_out[0]);
        end
      end
      if (k == 6) begin
        asserts++;
        if (bus.db_out[0] !== 1'b1 || bus.rise_p[0] !== 1'b1) begin
          failures++;
          $display("FAIL press_edge6 got db=%b rise=%b exp db=1 rise=1", bus.db_out[0], bus.rise_p[0]);
        end
      end
      if (k == 7) begin
        asserts++;
        if (bus.db_out[0] !== 1'b1 || bus.rise_p[0] !== 1'b0) begin
          failures++;
          $display("FAIL press_after got db=%b rise=%b exp db=1 rise=0", bus.db_out[0], bus.rise_p[0]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [10:0] pat;
    int          rises;
    pat   = 11'b111_1111_0111; // bit k-1 = din[1] at step k
    rises = 0;
    for (int k = 1; k <= 11; k++) begin
      step({2'b00, pat[k-1], 1'b1}, 1'b1, 1'b0);
      if (bus.rise_p[1] === 1'b1) rises++;
      if (k == 9) begin
        asserts++;
        if (bus.db_out[1] !== 1'b0) begin
          failures++;
          $display("FAIL bounce_early got=%b exp=0", bus.db_out[1]);
        end
      end
      if (k == 10) begin
        asserts++;
        if (bus.db_out[1] !== 1'b1) begin
          failures++;
          $display("FAIL bounce_edge6 got=%b exp=1", bus.db_out[1]);
        end
      end
    end
    asserts++;
    if (rises != 1) begin
      failures++;
      $display("FAIL bounce_rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_glitch();
    int hits;
    hits = 0;
    for (int k = 1; k <= 10; k++) begin
      step({1'b0, (k <= 3), 2'b11}, 1'b1, 1'b0);
      if (bus.db_out[2] !== 1'b0 || bus.rise_p[2] !== 1'b0 || bus.fall_p[2] !== 1'b0) hits++;
    end
    asserts++;
    if (hits != 0) begin
      failures++;
      $display("FAIL glitch_quiet got=%0d active cycles exp=0", hits);
    end
  endtask

  task automatic test_tick_gating();
    for (int k = 1; k <= 12; k++) begin
      step(4'b1011, (k % 2 == 0), 1'b0);
      if (k == 9) begin
        asserts++;
        if (bus.db_out[3] !== 1'b0) begin
          failures++;
          $display("FAIL tick_early got=%b exp=0", bus.db_out[3]);
        end
      end
      if (k == 10) begin
        asserts++;
        if (bus.db_out[3] !== 1'b1 || bus.rise_p[3] !== 1'b1) begin
          failures++;
          $display("FAIL tick_accept got db=%b rise=%b exp db=1 rise=1", bus.db_out[3], bus.rise_p[3]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b1);
    asserts++;
    if (bus.db_out !== 4'b0000 || bus.rise_p !== 4'b0000 || bus.fall_p !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_state got db=%b rise=%b fall=%b exp all 0000", bus.db_out, bus.rise_p, bus.fall_p);
    end
    for (int k = 1; k <= 7; k++) begin
      step(4'b0001, 1'b1, 1'b0);
      if (k == 5) begin
        asserts++;
        if (bus.db_out[0] !== 1'b0) begin
          failures++;
          $display("FAIL midreset_early got=%b exp=0", bus.db_out[0]);
        end
      end
      if (k == 6) begin
        asserts++;
        if (bus.db_out[0] !== 1'b1 || bus.rise_p[0] !== 1'b1) begin
          failures++;
          $display("FAIL midreset_edge6 got db=%b rise=%b exp db=1 rise=1", bus.db_out[0], bus.rise_p[0]);
        end
      end
    end
  endtask

  task automatic test_release_multi();
    for (int k = 1; k <= 8; k++) step(4'b1111, 1'b1, 1'b0);
    asserts++;
    if (bus.db_out !== 4'b1111) begin
      failures++;
      $display("FAIL release_setup got=%b exp=1111", bus.db_out);
    end
    for (int k = 1; k <= 7; k++) begin
      step(4'b0101, 1'b1, 1'b0);
      if (k == 5) begin
        asserts++;
        if (bus.db_out !== 4'b1111) begin
          failures++;
          $display("FAIL release_early got=%b exp=1111", bus.db_out);
        end
      end
      if (k == 6) begin
        asserts++;
        if (bus.db_out !== 4'b0101 || bus.fall_p !== 4'b1010 || bus.rise_p !== 4'b0000) begin
          failures++;
          $display("FAIL release_edge6 got db=%b fall=%b rise=%b exp db=0101 fall=1010 rise=0000",
                   bus.db_out, bus.fall_p, bus.rise_p);
        end
      end
      if (k == 7) begin
        asserts++;
        if (bus.fall_p !== 4'b0000) begin
          failures++;
          $display("FAIL release_after got fall=%b exp=0000", bus.fall_p);
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.din     = '0;
    bus.tick_en = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_tick_gating();
    test_reset_mid_count();
    test_release_multi();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    asserts++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
